multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS control FSM: sequences each instruction through fetch, decode, execute, memory and writeback cycles over a shared memory port. Drives the datapath strobes (PC, IR, register file, memory, ALU). Adds a mem_ready handshake with a wait-state timeout, a pipeline-style stall input, beq/j support, a retire pulse and a sticky fault report. Sits between the instruction register opcode field and the datapath muxes/enables.

## Interface
- TIMEOUT, 16: max consecutive cycles waiting on mem_ready before fault; 0 disables timeout
- CNT_W, $clog2(TIMEOUT+1) (min 1): wait-counter width, derived, not overridden
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; stable outside FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- stall  in  1  hold FSM this cycle
- pcwrite, irwrite, regwrite, memread, memwrite  out  1 each  datapath strobes
- iord  out  1  memory address: 0 = PC, 1 = ALU result
- regdest  out  1  write reg: 1 = rd, 0 = rt
- memtoreg  out  1  writeback: 1 = memory data, 0 = ALU
- alusrc  out  1  ALU B: 1 = sign-extended imm, 0 = rt
- aluop  out  2  00 add, 01 subtract, 10 funct decode
- pcsrc  out  2  00 PC+4, 01 branch target, 10 jump target
- instr_done  out  1  one-cycle pulse when an instruction retires
- fault  out  1  sticky; FSM in FAULT
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
- state  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11, FAULT 15.
- All outputs not listed for a state are 0. Outputs combinational from state, opcode, zero, mem_ready, stall.
- FETCH: memread=1, iord=0. When mem_ready: irwrite=1, pcwrite=1, pcsrc=00; next DECODE.
- DECODE: opcode 00→EXEC_R, 08→EXEC_I, 23/2B→ADDR, 04→BRANCH, 02→JUMP, else→FAULT, fault_code=01.
- EXEC_R: aluop=10, alusrc=0 → WB_R. WB_R: regwrite=1, regdest=1, instr_done=1 → FETCH.
- EXEC_I: aluop=00, alusrc=1 → WB_I. WB_I: regwrite=1, instr_done=1 → FETCH.
- ADDR: aluop=00, alusrc=1 → MEM_RD (opcode 23) or MEM_WR (2B).
- MEM_RD: memread=1, iord=1; on mem_ready → WB_MEM. WB_MEM: regwrite=1, memtoreg=1, instr_done=1 → FETCH.
- MEM_WR: memwrite=1, iord=1; on mem_ready: instr_done=1 → FETCH.
- BRANCH: aluop=01, alusrc=0, pcsrc=01, pcwrite=zero, instr_done=1 → FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1 → FETCH.
- FAULT: all strobes 0, fault=1; held until rst. fault_code holds cause.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready; increments each non-stalled cycle in those states with mem_ready=0. When TIMEOUT≠0 and counter reaches TIMEOUT with mem_ready still 0 → FAULT, fault_code=10. mem_ready in same cycle as the limit wins (completes normally).
- stall=1: state and counter hold; pcwrite, irwrite, regwrite, memwrite, instr_done forced 0; memread, iord, mux selects unchanged. mem_ready ignored while stalled.

## Timing
- rst asserted (any time, including mid-instruction): state=FETCH, counter=0, fault_code=00 immediately; all outputs forced 0 while rst high. First memread=1 in the cycle after rst deasserts.
- Latency with mem_ready=1 every cycle: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3 (FETCH to instr_done inclusive).
- Each cycle with mem_ready=0 in a memory state adds one cycle; each stall cycle adds one cycle.
- instr_done asserted in exactly one cycle per retired instruction; never in FAULT.

## Test plan
- Reset then R-type (opcode 00), mem_ready=1 → states 0,1,2,7,0; regwrite=regdest=1 and instr_done=1 in cycle 4 only.
- lw (23) with mem_ready low 3 cycles in MEM_RD → 8 cycles total; memtoreg=regwrite=1 once; no fault.
- beq (04) with zero=1 then zero=0 → pcwrite=1, pcsrc=01 in cycle 3 first case; pcwrite=0 second; both instr_done=1.
- Opcode 3F → FAULT after DECODE, fault=1, fault_code=01, all strobes 0 for 20 cycles; rst clears to FETCH, fault_code=00.
- TIMEOUT=16, mem_ready held 0 in FETCH → FAULT, fault_code=10 after 16 wait cycles; repeat with mem_ready=1 on the 16th cycle → DECODE, no fault.
- stall=1 during WB_R for 3 cycles → regwrite=0 and state 7 held; regwrite=1, instr_done=1 on the first cycle after stall drops; async rst mid-MEM_WR → memwrite drops immediately.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/memory/writeback and drives datapath strobes.
// Latency: R/addi 4, lw 5, sw 4, beq 3, j 3 cycles with mem_ready high; strobes are combinational from state and inputs.
// Backpressure: mem_ready low holds the memory states (bounded by TIMEOUT); stall freezes state and suppresses all write strobes.
module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       stall,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       regdest,
    output logic       memtoreg,
    output logic       alusrc,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state
);

    // Counter must be able to hold TIMEOUT itself; a zero timeout still needs a legal 1-bit vector.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    // The cycle in which the counter already holds TIMEOUT-1 is the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] LIM = LIM_I[CNT_W-1:0];

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       code;
    logic [1:0]       code_nx;
    logic             waiting;
    logic             expired;

    // States that sit on the shared memory port and may wait for mem_ready.
    assign waiting = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    // Limit reached with no completion this cycle; a late mem_ready still wins.
    assign expired = (TIMEOUT != 0) && waiting && !mem_ready && (cnt == LIM);

    // State, wait counter and sticky fault cause registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= S_FETCH;
            cnt  <= '0;
            code <= 2'b00;
        end else begin
            cur  <= nxt;
            cnt  <= cnt_nx;
            code <= code_nx;
        end
    end

    // Next state, next wait count and fault cause; everything holds while stalled.
    always_comb begin
        nxt     = cur;
        code_nx = code;
        cnt_nx  = cnt;
        if (!stall) begin
            case (cur)
                S_FETCH: begin
                    if (mem_ready) begin
                        nxt = S_DECODE;
                    end else if (expired) begin
                        nxt     = S_FAULT;
                        code_nx = 2'b10;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_R:         nxt = S_EXEC_R;
                        OP_ADDI:      nxt = S_EXEC_I;
                        OP_LW, OP_SW: nxt = S_ADDR;
                        OP_BEQ:       nxt = S_BRANCH;
                        OP_J:         nxt = S_JUMP;
                        default: begin
                            nxt     = S_FAULT;
                            code_nx = 2'b01;
                        end
                    endcase
                end
                S_EXEC_R: nxt = S_WB_R;
                S_EXEC_I: nxt = S_WB_I;
                S_ADDR:   nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready) begin
                        nxt = S_WB_MEM;
                    end else if (expired) begin
                        nxt     = S_FAULT;
                        code_nx = 2'b10;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        nxt = S_FETCH;
                    end else if (expired) begin
                        nxt     = S_FAULT;
                        code_nx = 2'b10;
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: nxt = S_FETCH;
                S_FAULT:  nxt = S_FAULT;
                default:  nxt = S_FETCH;
            endcase
            // Count only cycles that keep waiting in the same memory state; any change or completion clears.
            if ((TIMEOUT != 0) && waiting && !mem_ready && (nxt == cur)) begin
                cnt_nx = cnt + CNT_W'(1);
            end else begin
                cnt_nx = '0;
            end
        end
    end

    // Datapath strobes from the current state; stall kills writes, reset kills everything.
    always_comb begin
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        regdest    = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        fault      = 1'b0;
        fault_code = code;
        state      = cur;
        case (cur)
            S_FETCH: begin
                memread = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                end
            end
            S_EXEC_R: aluop = 2'b10;
            S_EXEC_I: alusrc = 1'b1;
            S_ADDR:   alusrc = 1'b1;
            S_MEM_RD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_WB_R: begin
                regwrite   = 1'b1;
                regdest    = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_I: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                pcwrite    = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            S_FAULT:  fault = 1'b1;
            default:  fault = 1'b0;
        endcase
        if (stall) begin
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
        end
        if (rst) begin
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            regdest    = 1'b0;
            memtoreg   = 1'b0;
            alusrc     = 1'b0;
            aluop      = 2'b00;
            pcsrc      = 2'b00;
            instr_done = 1'b0;
            fault      = 1'b0;
            fault_code = 2'b00;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of directed vectors, hand-written corner sequences, then random traffic.
// Inputs are driven 2 time units after the rising edge and outputs sampled 1 unit later.
// The random phase compares every cycle against an instruction-level reference model.
module tb_multicycle_control;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       stall = 1'b0;
    logic       pcwrite, irwrite, regwrite, memread, memwrite, iord, regdest, memtoreg, alusrc;
    logic [1:0] aluop, pcsrc, fault_code;
    logic       instr_done, fault;
    logic [3:0] state;

    multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .stall(stall),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .iord(iord), .regdest(regdest), .memtoreg(memtoreg),
        .alusrc(alusrc), .aluop(aluop), .pcsrc(pcsrc), .instr_done(instr_done),
        .fault(fault), .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regdest;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       fault;
        logic [1:0] fault_code;
        logic [3:0] state;
    } out_t;

    typedef struct {
        string      nm;
        logic       r;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic       st;
        out_t       exp;
    } vec_t;

    out_t got;
    assign got = {pcwrite, irwrite, regwrite, memread, memwrite, iord, regdest, memtoreg,
                  alusrc, aluop, pcsrc, instr_done, fault, fault_code, state};

    int   vectors = 0;
    int   miscompares = 0;
    vec_t vt[$];
    out_t base[16];
    out_t ZERO, FETCH_OK, FETCH_WAIT, DEC;

    // Reference model: position within the instruction's step list plus plain wait/fault bookkeeping.
    int       m_pos = 0;
    int       m_wait = 0;
    bit       m_fault = 0;
    logic [1:0] m_code = 2'b00;

    task automatic check(input string nm, input out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                     nm, got.state, got, exp.state, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr, input logic st);
        rst = r; opcode = op; zero = z; mem_ready = mr; stall = st;
    endtask

    task automatic cyc(input string nm, input logic r, input logic [5:0] op, input logic z,
                       input logic mr, input logic st, input out_t exp);
        drive(r, op, z, mr, st);
        #1;
        check(nm, exp);
        @(posedge clk);
        #2;
    endtask

    task automatic add(input string nm, input logic r, input logic [5:0] op, input logic z,
                       input logic mr, input logic st, input out_t exp);
        vec_t v;
        v.nm = nm; v.r = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.exp = exp;
        vt.push_back(v);
    endtask

    task automatic do_reset(input logic [5:0] op);
        cyc("reset", 1'b1, op, 1'b0, 1'b0, 1'b0, ZERO);
    endtask

    // Steps of an instruction: 0 fetch, 1 decode, then opcode-specific; -1 means retired.
    function automatic int path_at(input logic [5:0] op, input int k);
        int s[4];
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (op)
            6'h00:   s = '{2, 7, -1, -1};
            6'h08:   s = '{3, 8, -1, -1};
            6'h23:   s = '{4, 5, 9, -1};
            6'h2B:   s = '{4, 6, -1, -1};
            6'h04:   s = '{10, -1, -1, -1};
            6'h02:   s = '{11, -1, -1, -1};
            default: s = '{15, -1, -1, -1};
        endcase
        return (k - 2 < 4) ? s[k - 2] : -1;
    endfunction

    task automatic model_step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                              input logic st, output out_t e);
        int  cs;
        int  nx;
        bit  memst;
        e = '0;
        if (r) begin
            m_pos = 0; m_wait = 0; m_fault = 0; m_code = 2'b00;
            return;
        end
        cs = m_fault ? 15 : path_at(op, m_pos);
        e  = base[cs];
        case (cs)
            0:  if (mr) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
            6:  e.instr_done = mr;
            10: e.pcwrite = z;
            15: e.fault_code = m_code;
            default: ;
        endcase
        if (st) begin
            e.pcwrite = 0; e.irwrite = 0; e.regwrite = 0; e.memwrite = 0; e.instr_done = 0;
        end
        if (st || m_fault) return;
        memst = (cs == 0) || (cs == 5) || (cs == 6);
        if (memst && !mr) begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_fault = 1; m_code = 2'b10;
            end
        end else begin
            m_wait = 0;
            m_pos++;
            nx = path_at(op, m_pos);
            if (nx < 0) m_pos = 0;
            else if (nx == 15) begin
                m_fault = 1; m_code = 2'b01;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] cur_op;
        out_t       e;
        int         starve;
        int         fault_age;
        logic       r, z, mr, st;

        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        ZERO       = '0;
        FETCH_OK   = '{state: 4'd0, memread: 1'b1, irwrite: 1'b1, pcwrite: 1'b1, default: 0};
        FETCH_WAIT = '{state: 4'd0, memread: 1'b1, default: 0};
        DEC        = '{state: 4'd1, default: 0};
        base[0]  = FETCH_WAIT;
        base[1]  = DEC;
        base[2]  = '{state: 4'd2, aluop: 2'b10, default: 0};
        base[3]  = '{state: 4'd3, alusrc: 1'b1, default: 0};
        base[4]  = '{state: 4'd4, alusrc: 1'b1, default: 0};
        base[5]  = '{state: 4'd5, memread: 1'b1, iord: 1'b1, default: 0};
        base[6]  = '{state: 4'd6, memwrite: 1'b1, iord: 1'b1, default: 0};
        base[7]  = '{state: 4'd7, regwrite: 1'b1, regdest: 1'b1, instr_done: 1'b1, default: 0};
        base[8]  = '{state: 4'd8, regwrite: 1'b1, instr_done: 1'b1, default: 0};
        base[9]  = '{state: 4'd9, regwrite: 1'b1, memtoreg: 1'b1, instr_done: 1'b1, default: 0};
        base[10] = '{state: 4'd10, aluop: 2'b01, pcsrc: 2'b01, instr_done: 1'b1, default: 0};
        base[11] = '{state: 4'd11, pcsrc: 2'b10, pcwrite: 1'b1, instr_done: 1'b1, default: 0};
        base[12] = '0; base[13] = '0; base[14] = '0;
        base[15] = '{state: 4'd15, fault: 1'b1, default: 0};

        @(posedge clk);
        #2;

        // Directed table: R-type, beq taken/untaken, j, addi, sw, all with mem_ready high.
        add("rst_state",   1, 6'h00, 0, 1, 0, ZERO);
        add("r_fetch",     0, 6'h00, 0, 1, 0, FETCH_OK);
        add("r_decode",    0, 6'h00, 0, 1, 0, DEC);
        add("r_exec",      0, 6'h00, 0, 1, 0, '{state: 4'd2, aluop: 2'b10, default: 0});
        add("r_wb",        0, 6'h00, 0, 1, 0, '{state: 4'd7, regwrite: 1'b1, regdest: 1'b1, instr_done: 1'b1, default: 0});
        add("beq1_fetch",  0, 6'h04, 1, 1, 0, FETCH_OK);
        add("beq1_decode", 0, 6'h04, 1, 1, 0, DEC);
        add("beq_taken",   0, 6'h04, 1, 1, 0, '{state: 4'd10, aluop: 2'b01, pcsrc: 2'b01, pcwrite: 1'b1, instr_done: 1'b1, default: 0});
        add("beq0_fetch",  0, 6'h04, 0, 1, 0, FETCH_OK);
        add("beq0_decode", 0, 6'h04, 0, 1, 0, DEC);
        add("beq_untaken", 0, 6'h04, 0, 1, 0, '{state: 4'd10, aluop: 2'b01, pcsrc: 2'b01, instr_done: 1'b1, default: 0});
        add("j_fetch",     0, 6'h02, 0, 1, 0, FETCH_OK);
        add("j_decode",    0, 6'h02, 0, 1, 0, DEC);
        add("j_jump",      0, 6'h02, 0, 1, 0, '{state: 4'd11, pcsrc: 2'b10, pcwrite: 1'b1, instr_done: 1'b1, default: 0});
        add("addi_fetch",  0, 6'h08, 0, 1, 0, FETCH_OK);
        add("addi_decode", 0, 6'h08, 0, 1, 0, DEC);
        add("addi_exec",   0, 6'h08, 0, 1, 0, '{state: 4'd3, alusrc: 1'b1, default: 0});
        add("addi_wb",     0, 6'h08, 0, 1, 0, '{state: 4'd8, regwrite: 1'b1, instr_done: 1'b1, default: 0});
        add("sw_fetch",    0, 6'h2B, 0, 1, 0, FETCH_OK);
        add("sw_decode",   0, 6'h2B, 0, 1, 0, DEC);
        add("sw_addr",     0, 6'h2B, 0, 1, 0, '{state: 4'd4, alusrc: 1'b1, default: 0});
        add("sw_write",    0, 6'h2B, 0, 1, 0, '{state: 4'd6, memwrite: 1'b1, iord: 1'b1, instr_done: 1'b1, default: 0});
        add("sw_next",     0, 6'h00, 0, 0, 0, FETCH_WAIT);
        foreach (vt[i]) cyc(vt[i].nm, vt[i].r, vt[i].op, vt[i].z, vt[i].mr, vt[i].st, vt[i].exp);

        // lw with three wait cycles in MEM_RD: eight cycles from fetch to retire.
        do_reset(6'h23);
        cyc("lw_fetch",  0, 6'h23, 0, 1, 0, FETCH_OK);
        cyc("lw_decode", 0, 6'h23, 0, 1, 0, DEC);
        cyc("lw_addr",   0, 6'h23, 0, 1, 0, '{state: 4'd4, alusrc: 1'b1, default: 0});
        for (int i = 0; i < 3; i++) cyc("lw_wait", 0, 6'h23, 0, 0, 0, base[5]);
        cyc("lw_ready",  0, 6'h23, 0, 1, 0, base[5]);
        cyc("lw_wb",     0, 6'h23, 0, 1, 0, base[9]);
        cyc("lw_next",   0, 6'h23, 0, 0, 0, FETCH_WAIT);

        // Illegal opcode: sticky fault with code 01 until reset.
        do_reset(6'h3F);
        cyc("ill_fetch",  0, 6'h3F, 0, 1, 0, FETCH_OK);
        cyc("ill_decode", 0, 6'h3F, 0, 1, 0, DEC);
        for (int i = 0; i < 20; i++)
            cyc("ill_fault", 0, 6'h3F, 1'($urandom), 1'($urandom), 1'($urandom),
                '{state: 4'd15, fault: 1'b1, fault_code: 2'b01, default: 0});
        cyc("ill_rst",    1, 6'h3F, 0, 1, 0, ZERO);
        cyc("ill_after",  0, 6'h00, 0, 0, 0, FETCH_WAIT);

        // Fetch timeout after 16 wait cycles, then the same run rescued on the 16th cycle.
        do_reset(6'h00);
        for (int i = 0; i < TIMEOUT; i++) cyc("to_wait", 0, 6'h00, 0, 0, 0, FETCH_WAIT);
        cyc("to_fault", 0, 6'h00, 0, 0, 0, '{state: 4'd15, fault: 1'b1, fault_code: 2'b10, default: 0});
        do_reset(6'h00);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc("to_wait2", 0, 6'h00, 0, 0, 0, FETCH_WAIT);
        cyc("to_late_ready", 0, 6'h00, 0, 1, 0, FETCH_OK);
        cyc("to_decode",     0, 6'h00, 0, 1, 0, DEC);

        // Stall held three cycles in WB_R.
        do_reset(6'h00);
        cyc("st_fetch",  0, 6'h00, 0, 1, 0, FETCH_OK);
        cyc("st_decode", 0, 6'h00, 0, 1, 0, DEC);
        cyc("st_exec",   0, 6'h00, 0, 1, 0, base[2]);
        for (int i = 0; i < 3; i++) cyc("st_hold", 0, 6'h00, 0, 1, 1, '{state: 4'd7, regdest: 1'b1, default: 0});
        cyc("st_release", 0, 6'h00, 0, 1, 0, base[7]);
        cyc("st_next",    0, 6'h00, 0, 1, 0, FETCH_OK);

        // Asynchronous reset in the middle of a waiting store.
        do_reset(6'h2B);
        cyc("ar_fetch",  0, 6'h2B, 0, 1, 0, FETCH_OK);
        cyc("ar_decode", 0, 6'h2B, 0, 1, 0, DEC);
        cyc("ar_addr",   0, 6'h2B, 0, 1, 0, base[4]);
        drive(0, 6'h2B, 0, 0, 0);
        #1;
        check("ar_memwr", base[6]);
        #1;
        rst = 1'b1;
        #1;
        check("ar_async_rst", ZERO);
        @(posedge clk);
        #2;
        cyc("ar_after", 0, 6'h2B, 0, 0, 0, FETCH_WAIT);

        // Random traffic against the reference model.
        do_reset(6'h00);
        m_pos = 0; m_wait = 0; m_fault = 0; m_code = 2'b00;
        cur_op = 6'h00; starve = 0; fault_age = 0;
        for (int n = 0; n < 3000; n++) begin
            r = (m_fault && fault_age > 4) || ($urandom_range(0, 299) == 0);
            if (!m_fault && m_pos == 0)
                cur_op = ($urandom_range(0, 39) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            if (starve > 0) begin
                mr = 1'b0;
                starve--;
            end else begin
                mr = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 149) == 0) starve = 20;
            end
            st = ($urandom_range(0, 6) == 0);
            z  = 1'($urandom);
            drive(r, cur_op, z, mr, st);
            #1;
            model_step(r, cur_op, z, mr, st, e);
            check("random", e);
            fault_age = m_fault ? fault_age + 1 : 0;
            @(posedge clk);
            #2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
